// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NM masters.
// A per-tenure stall watchdog errors out a hung slave and forces a one-cycle bus recovery.
module wb_rr_arbiter #(
    parameter int unsigned NM      = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    input  logic [NM-1:0]          wbm_cyc_i,
    input  logic [NM-1:0]          wbm_stb_i,
    input  logic [NM-1:0]          wbm_we_i,
    input  logic [NM*AW-1:0]       wbm_adr_i,
    input  logic [NM*DW-1:0]       wbm_dat_i,
    input  logic [NM*(DW/8)-1:0]   wbm_sel_i,
    output logic [NM-1:0]          wbm_ack_o,
    output logic [NM-1:0]          wbm_err_o,
    output logic [DW-1:0]          wbm_dat_o,
    output logic                   wbs_cyc_o,
    output logic                   wbs_stb_o,
    output logic                   wbs_we_o,
    output logic [AW-1:0]          wbs_adr_o,
    output logic [DW-1:0]          wbs_dat_o,
    output logic [DW/8-1:0]        wbs_sel_o,
    input  logic                   wbs_ack_i,
    input  logic [DW-1:0]          wbs_dat_i,
    output logic [NM-1:0]          grant_o
);
    localparam int unsigned SW = DW / 8;
    localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;

    state_t          state_q, state_d;
    logic [NM-1:0]   grant_q, grant_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NM-1:0]   err_q, err_d;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    int unsigned     scan;

    logic            own_cyc, own_stb, own_we;
    logic [AW-1:0]   own_adr;
    logic [DW-1:0]   own_dat;
    logic [SW-1:0]   own_sel;
    logic            busy;

    // First requester found scanning upward from the master after last_grant.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = last_q;
        scan       = 0;
        for (int unsigned i = 1; i <= NM; i++) begin
            scan = (32'(last_q) + i) % NM;
            if (!pick_valid && wbm_cyc_i[scan]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(scan);
            end
        end
    end

    // Owner's request, selected by the one-hot grant (all zero when nobody owns the bus).
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        for (int unsigned m = 0; m < NM; m++) begin
            if (grant_q[m]) begin
                own_cyc = wbm_cyc_i[m];
                own_stb = wbm_cyc_i[m] & wbm_stb_i[m];
                own_we  = wbm_we_i[m];
                own_adr = wbm_adr_i[m*AW +: AW];
                own_dat = wbm_dat_i[m*DW +: DW];
                own_sel = wbm_sel_i[m*SW +: SW];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NM - 1);
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state: an ack on the final stalled cycle beats the timeout.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = '0;
        err_d   = '0;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_valid) begin
                    state_d = BUSY;
                    grant_d = NM'(1) << pick_idx;
                    last_d  = pick_idx;
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (own_stb && !wbs_ack_i) begin
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d = RECOVER;
                        grant_d = '0;
                        err_d   = grant_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            RECOVER: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Slave-side request and master-side response paths, zero outside a tenure.
    always_comb begin
        busy      = (state_q == BUSY);
        wbs_cyc_o = busy & own_cyc;
        wbs_stb_o = busy & own_stb;
        wbs_we_o  = busy & own_we;
        wbs_adr_o = busy ? own_adr : '0;
        wbs_dat_o = busy ? own_dat : '0;
        wbs_sel_o = busy ? own_sel : '0;
        wbm_ack_o = busy ? (grant_q & {NM{wbs_ack_i}}) : '0;
        wbm_dat_o = wbs_dat_i;
        wbm_err_o = err_q;
        grant_o   = grant_q;
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter (NM=2, TIMEOUT=4); transfers are scoreboarded
// when issued and retired on the slave acknowledge cycle.
module tb_wb_rr_arbiter;
    localparam int unsigned NM = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     cyc, stb, we;
    logic [NM*AW-1:0]  adr;
    logic [NM*DW-1:0]  wdat;
    logic [NM*SW-1:0]  sel;
    logic              s_ack;
    logic [DW-1:0]     s_dat;

    logic [NM-1:0]     wbm_ack_o, wbm_err_o, grant_o;
    logic [DW-1:0]     wbm_dat_o, wbs_dat_o;
    logic              wbs_cyc_o, wbs_stb_o, wbs_we_o;
    logic [AW-1:0]     wbs_adr_o;
    logic [SW-1:0]     wbs_sel_o;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic        we;
        logic [1:0]  gnt;
        logic [31:0] rdat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbm_cyc_i  (cyc),
        .wbm_stb_i  (stb),
        .wbm_we_i   (we),
        .wbm_adr_i  (adr),
        .wbm_dat_i  (wdat),
        .wbm_sel_i  (sel),
        .wbm_ack_o  (wbm_ack_o),
        .wbm_err_o  (wbm_err_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbs_cyc_o  (wbs_cyc_o),
        .wbs_stb_o  (wbs_stb_o),
        .wbs_we_o   (wbs_we_o),
        .wbs_adr_o  (wbs_adr_o),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_sel_o  (wbs_sel_o),
        .wbs_ack_i  (s_ack),
        .wbs_dat_i  (s_dat),
        .grant_o    (grant_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int m, input logic c, input logic s, input logic w,
                             input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
        cyc[m] = c;
        stb[m] = s;
        we[m]  = w;
        adr[m*AW +: AW]  = a;
        wdat[m*DW +: DW] = d;
        sel[m*SW +: SW]  = sl;
    endtask

    // Owner m is already granted; issue one transfer acked after lat stalled cycles.
    task automatic xfer(input int m, input logic [31:0] a, input logic w, input logic [31:0] d,
                        input int lat, input logic [31:0] rd);
        exp_t e;
        logic [3:0] sl;
        sl = w ? 4'hf : 4'h3;
        drive_req(m, 1'b1, 1'b1, w, a, d, sl);
        e.adr = a; e.wdat = d; e.sel = sl; e.we = w; e.gnt = 2'(1 << m); e.rdat = rd;
        sb_q.push_back(e);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            n_checks++;
            if (wbm_ack_o !== 2'b00 || wbm_err_o !== 2'b00 || wbs_stb_o !== 1'b1)
                $display("FAIL xfer_stall: ack=%b err=%b stb=%b want ack=00 err=00 stb=1",
                         wbm_ack_o, wbm_err_o, wbs_stb_o);
            else n_pass++;
            step();
        end
        s_ack = 1'b1;
        s_dat = rd;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_empty: no expected transfer queued");
        end else begin
            e = sb_q.pop_front();
            n_checks++;
            if ({wbs_adr_o, wbs_we_o, wbs_sel_o, wbs_dat_o} !== {e.adr, e.we, e.sel, e.wdat})
                $display("FAIL slave_req: adr=%h we=%b sel=%h dat=%h want adr=%h we=%b sel=%h dat=%h",
                         wbs_adr_o, wbs_we_o, wbs_sel_o, wbs_dat_o, e.adr, e.we, e.sel, e.wdat);
            else n_pass++;
            n_checks++;
            if (wbm_ack_o !== e.gnt || grant_o !== e.gnt)
                $display("FAIL master_ack: ack=%b grant=%b want %b", wbm_ack_o, grant_o, e.gnt);
            else n_pass++;
            n_checks++;
            if (wbm_dat_o !== e.rdat)
                $display("FAIL read_data: got %h want %h", wbm_dat_o, e.rdat);
            else n_pass++;
        end
        step();
        s_ack = 1'b0;
        stb[m] = 1'b0;
    endtask

    // Owner drops cyc; bus goes quiet and one dead arbitration cycle follows.
    task automatic drop_bus(input int m);
        cyc[m] = 1'b0;
        stb[m] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wbs_cyc_o !== 1'b0 || wbm_err_o !== 2'b00)
            $display("FAIL drop_cyc: wbs_cyc=%b err=%b want 0 00", wbs_cyc_o, wbm_err_o);
        else n_pass++;
        step();
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b00) $display("FAIL dead_cycle: grant=%b want 00", grant_o);
        else n_pass++;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc = '0; stb = '0; we = '0; adr = '0; wdat = '0; sel = '0;
        s_ack = 1'b0;
        s_dat = 32'h1234_5678;
        step();
        step();
        @(negedge clk);
        n_checks++;
        if ({grant_o, wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o} !== 8'b0)
            $display("FAIL reset_state: grant=%b cyc=%b stb=%b ack=%b err=%b want all 0",
                     grant_o, wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o);
        else n_pass++;
        n_checks++;
        if (wbm_dat_o !== 32'h1234_5678) $display("FAIL dat_passthru: got %h want 12345678", wbm_dat_o);
        else n_pass++;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b00 || wbs_cyc_o !== 1'b0)
            $display("FAIL idle_no_req: grant=%b cyc=%b want 00 0", grant_o, wbs_cyc_o);
        else n_pass++;
        step();
    endtask

    task automatic test_single_master();
        drive_req(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b00 || wbs_cyc_o !== 1'b0)
            $display("FAIL single_arb: grant=%b cyc=%b want 00 0", grant_o, wbs_cyc_o);
        else n_pass++;
        step();
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b10 || wbs_cyc_o !== 1'b1 || wbs_stb_o !== 1'b0)
            $display("FAIL single_grant: grant=%b cyc=%b stb=%b want 10 1 0", grant_o, wbs_cyc_o, wbs_stb_o);
        else n_pass++;
        step();
        xfer(1, 32'h100, 1'b0, 32'h0, 2, 32'hCAFE_0001);
        drop_bus(1);
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cyc = 2'b11;
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b00) $display("FAIL rr_arb: grant=%b want 00", grant_o);
        else n_pass++;
        step();
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b01) $display("FAIL rr_first: grant=%b want 01", grant_o);
        else n_pass++;
        step();
        xfer(0, 32'h200, 1'b0, 32'h0, 0, 32'h0000_A000);
        drop_bus(0);
        cyc[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b10) $display("FAIL rr_second: grant=%b want 10", grant_o);
        else n_pass++;
        step();
        xfer(1, 32'h204, 1'b0, 32'h0, 1, 32'h0000_A001);
        drop_bus(1);
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b01) $display("FAIL rr_third: grant=%b want 01", grant_o);
        else n_pass++;
        step();
        xfer(0, 32'h208, 1'b1, 32'h0000_0055, 0, 32'h0000_A002);
        drop_bus(0);
    endtask

    task automatic test_back_to_back();
        cyc[0] = 1'b1;
        step();
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b01) $display("FAIL b2b_grant: grant=%b want 01", grant_o);
        else n_pass++;
        step();
        cyc[1] = 1'b1;
        xfer(0, 32'h10, 1'b1, 32'h1111_0010, 0, 32'h0);
        xfer(0, 32'h14, 1'b1, 32'h1111_0014, 1, 32'h0);
        xfer(0, 32'h18, 1'b1, 32'h1111_0018, 2, 32'h0);
        drop_bus(0);
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b10) $display("FAIL b2b_handover: grant=%b want 10", grant_o);
        else n_pass++;
        step();
        xfer(1, 32'h20, 1'b0, 32'h0, 0, 32'h5A5A_0020);
        drop_bus(1);
    endtask

    task automatic test_timeout_err();
        cyc[0] = 1'b1;
        step();
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b01) $display("FAIL to_grant: grant=%b want 01", grant_o);
        else n_pass++;
        step();
        drive_req(0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 4'h3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (wbm_err_o !== 2'b00 || wbs_stb_o !== 1'b1 || wbm_ack_o !== 2'b00)
                $display("FAIL to_stall%0d: err=%b stb=%b ack=%b want 00 1 00", i, wbm_err_o, wbs_stb_o, wbm_ack_o);
            else n_pass++;
            step();
        end
        s_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wbm_err_o !== 2'b01) $display("FAIL to_err: err=%b want 01", wbm_err_o);
        else n_pass++;
        n_checks++;
        if (wbs_cyc_o !== 1'b0 || grant_o !== 2'b00 || wbm_ack_o !== 2'b00)
            $display("FAIL to_recover: cyc=%b grant=%b ack=%b want 0 00 00", wbs_cyc_o, grant_o, wbm_ack_o);
        else n_pass++;
        step();
        drive_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        s_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wbm_err_o !== 2'b00 || grant_o !== 2'b00)
            $display("FAIL to_err_pulse: err=%b grant=%b want 00 00", wbm_err_o, grant_o);
        else n_pass++;
        step();
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b00 || wbs_cyc_o !== 1'b0)
            $display("FAIL to_idle: grant=%b cyc=%b want 00 0", grant_o, wbs_cyc_o);
        else n_pass++;
        step();
    endtask

    task automatic test_ack_at_timeout();
        cyc[1] = 1'b1;
        step();
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b10) $display("FAIL at_grant: grant=%b want 10", grant_o);
        else n_pass++;
        step();
        xfer(1, 32'h400, 1'b0, 32'h0, 3, 32'hBEEF_0004);
        drop_bus(1);
    endtask

    task automatic test_reset_mid_transfer();
        cyc[0] = 1'b1;
        step();
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b01) $display("FAIL rst_pre_grant: grant=%b want 01", grant_o);
        else n_pass++;
        step();
        drive_req(0, 1'b1, 1'b1, 1'b1, 32'h500, 32'h0000_0500, 4'hf);
        step();
        #2;
        rst_n = 1'b0;
        s_ack = 1'b1;
        cyc[1] = 1'b1;
        #1;
        n_checks++;
        if ({wbs_cyc_o, wbs_stb_o, grant_o, wbm_ack_o, wbm_err_o} !== 8'b0)
            $display("FAIL rst_async: cyc=%b stb=%b grant=%b ack=%b err=%b want all 0",
                     wbs_cyc_o, wbs_stb_o, grant_o, wbm_ack_o, wbm_err_o);
        else n_pass++;
        step();
        rst_n = 1'b1;
        s_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b00) $display("FAIL rst_idle: grant=%b want 00", grant_o);
        else n_pass++;
        step();
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b01) $display("FAIL rst_first_grant: grant=%b want 01", grant_o);
        else n_pass++;
        step();
        cyc = '0;
        stb = '0;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single_master();
        test_round_robin();
        test_back_to_back();
        test_timeout_err();
        test_ack_at_timeout();
        test_reset_mid_transfer();
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL sb_leftover: %0d transfers never acked", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
